// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// Stopwatch control unit: push-button conditioning, start/pause/clear FSM,
// and the seconds prescaler that drives the digit counters.
module stopwatch_ctrl #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned TICK_DIV   = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic       switch,
  output logic       tick_sec,
  output logic       clear,
  output logic       running,
  output logic [1:0] state,
  output logic       btn_press
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  logic             sync_a;
  logic             btn_s;
  logic             deb_lvl;
  logic             deb_lvl_q;
  logic [DEB_W-1:0] deb_cnt;

  state_t           state_q;
  state_t           state_d;
  logic [PRE_W-1:0] presc_q;
  logic [PRE_W-1:0] presc_d;
  logic             tick_d;
  logic             clear_d;
  logic             running_d;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_a <= button;
      btn_s  <= sync_a;
    end
  end

  // Level only follows btn_s after DEB_CYCLES consecutive disagreeing clocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_cnt   <= '0;
      deb_lvl   <= 1'b0;
      deb_lvl_q <= 1'b0;
    end else begin
      deb_lvl_q <= deb_lvl;
      if (btn_s == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_lvl <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign btn_press = deb_lvl & ~deb_lvl_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      tick_sec <= 1'b0;
      clear    <= 1'b0;
      running  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tick_sec <= tick_d;
      clear    <= clear_d;
      running  <= running_d;
    end
  end

  // Next state, prescaler and registered pulse outputs.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (btn_press) state_d = RUN;
      end
      RUN: begin
        if (presc_q == PRE_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
        if (btn_press) state_d = PAUSE;
      end
      PAUSE: begin
        if (btn_press) begin
          if (switch) begin
            state_d = IDLE;
            clear_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        clear_d = 1'b1;
      end
    endcase
    // Leaving for IDLE drops the fractional second at once.
    if (state_d == IDLE) presc_d = '0;
    running_d = (state_d == RUN);
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
// Directed bench for stopwatch_ctrl: debounce latency, FSM sequencing,
// prescaler hold/wrap and asynchronous reset behaviour.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  logic       clock = 1'b0;
  logic       reset;
  logic       button;
  logic       switch;
  logic       tick_sec;
  logic       clear;
  logic       running;
  logic [1:0] state;
  logic       btn_press;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int clear_cnt = 0;
  int press_cnt = 0;
  int overlap_cnt = 0;

  stopwatch_ctrl #(.DEB_CYCLES(16), .TICK_DIV(50)) dut (
    .clock     (clock),
    .reset     (reset),
    .button    (button),
    .switch    (switch),
    .tick_sec  (tick_sec),
    .clear     (clear),
    .running   (running),
    .state     (state),
    .btn_press (btn_press)
  );

  always #1 clock = ~clock;

  always @(negedge clock) begin
    if (tick_sec) tick_cnt = tick_cnt + 1;
    if (clear) clear_cnt = clear_cnt + 1;
    if (btn_press) press_cnt = press_cnt + 1;
    if (tick_sec && clear) overlap_cnt = overlap_cnt + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_tick(input int max, output int k);
    k = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      if (tick_sec) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_press(input int max, output int k);
    k = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      if (btn_press) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, output int k);
    k = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      if (state === s) begin
        k = i;
        break;
      end
    end
  endtask

  // Press the button cleanly; the state is expected to change 19 clocks later.
  task automatic press_to(input logic [1:0] s, input string tag);
    int k;
    button = 1'b1;
    wait_state(s, 40, k);
    check_eq(tag, k, 19);
  endtask

  task automatic release_btn();
    button = 1'b0;
    cycles(25);
  endtask

  initial begin
    int k;
    int t0;
    int p0;
    int c0;
    int elapsed;
    int d;
    logic lvl;

    reset  = 1'b0;
    button = 1'b0;
    switch = 1'b0;
    cycles(3);
    check_eq("reset_state", int'(state), int'(S_IDLE));
    check_eq("reset_tick", int'(tick_sec), 0);
    reset = 1'b1;
    cycles(1);
    check_eq("idle_state", int'(state), int'(S_IDLE));
    check_eq("idle_tick", int'(tick_sec), 0);
    check_eq("idle_clear", int'(clear), 0);
    check_eq("idle_running", int'(running), 0);
    check_eq("idle_press", int'(btn_press), 0);
    t0 = tick_cnt;
    cycles(2000);
    check_eq("idle_no_tick", tick_cnt - t0, 0);
    check_eq("idle_still", int'(state), int'(S_IDLE));

    // Clean press: deb_lvl moves on edge 18, FSM on edge 19.
    p0 = press_cnt;
    button = 1'b1;
    wait_press(40, k);
    check_eq("press_latency", k, 18);
    wait_state(S_RUN, 5, k);
    check_eq("run_latency", k, 1);
    check_eq("run_running", int'(running), 1);
    wait_tick(60, k);
    check_eq("first_tick", k, 50);
    wait_tick(60, k);
    check_eq("tick_period", k, 50);
    check_eq("single_press", press_cnt - p0, 1);
    release_btn();
    cycles(40);
    check_eq("release_no_press", press_cnt - p0, 1);
    check_eq("release_still_run", int'(state), int'(S_RUN));

    // Short glitches and a bounce burst.
    p0 = press_cnt;
    repeat (4) begin
      button = 1'b1;
      cycles(5);
      button = 1'b0;
      cycles(10);
    end
    check_eq("glitch_no_press", press_cnt - p0, 0);
    check_eq("glitch_state", int'(state), int'(S_RUN));
    lvl = 1'b0;
    elapsed = 0;
    while (elapsed < 200) begin
      lvl = ~lvl;
      button = lvl;
      d = int'($urandom_range(1, 10));
      cycles(d);
      elapsed = elapsed + d;
    end
    check_eq("burst_no_press", press_cnt - p0, 0);
    button = 1'b1;
    wait_state(S_PAUSE, 60, k);
    check_eq("burst_pause", int'(k > 0), 1);
    cycles(30);
    check_eq("burst_one_press", press_cnt - p0, 1);
    release_btn();

    switch = 1'b0;
    press_to(S_RUN, "resume_setup");
    release_btn();

    // Pause with prescaler at 20, hold 1000 clocks, resume.
    wait_tick(60, k);
    check_eq("pre_pause_tick", int'(k > 0), 1);
    @(negedge clock);
    button = 1'b1;
    wait_state(S_PAUSE, 40, k);
    check_eq("pause_at_20", k, 19);
    t0 = tick_cnt;
    button = 1'b0;
    cycles(1000);
    check_eq("pause_no_tick", tick_cnt - t0, 0);
    check_eq("pause_running", int'(running), 0);
    press_to(S_RUN, "resume_press");
    wait_tick(60, k);
    check_eq("resume_tick_30", k, 30);
    release_btn();

    // Pause, then clear back to IDLE with switch=1.
    press_to(S_PAUSE, "pause2");
    release_btn();
    switch = 1'b1;
    c0 = clear_cnt;
    press_to(S_IDLE, "clear_to_idle");
    check_eq("clear_pulse", int'(clear), 1);
    check_eq("clear_no_tick", int'(tick_sec), 0);
    cycles(1);
    check_eq("clear_one_cycle", int'(clear), 0);
    release_btn();
    check_eq("clear_count", clear_cnt - c0, 1);
    check_eq("idle_not_running", int'(running), 0);
    press_to(S_RUN, "idle_to_run_sw1");
    wait_tick(60, k);
    check_eq("after_clear_tick_50", k, 50);
    switch = 1'b0;
    release_btn();

    // Press lands on terminal count: tick still issued and prescaler wraps.
    wait_tick(60, k);
    check_eq("tc_ref_tick", int'(k > 0), 1);
    cycles(31);
    button = 1'b1;
    wait_state(S_PAUSE, 40, k);
    check_eq("tc_pause", k, 19);
    check_eq("tc_tick", int'(tick_sec), 1);
    check_eq("tc_no_clear", int'(clear), 0);
    release_btn();
    press_to(S_RUN, "tc_resume");
    wait_tick(60, k);
    check_eq("tc_wrap_tick_50", k, 50);

    // Asynchronous reset while tick_sec is high, button held throughout.
    #0.3 reset = 1'b0;
    #0.1;
    check_eq("async_tick", int'(tick_sec), 0);
    check_eq("async_state", int'(state), int'(S_IDLE));
    check_eq("async_running", int'(running), 0);
    check_eq("async_clear", int'(clear), 0);
    check_eq("async_press", int'(btn_press), 0);
    cycles(3);
    c0 = clear_cnt;
    reset = 1'b1;
    wait_state(S_RUN, 40, k);
    check_eq("held_at_reset", k, 19);
    check_eq("reset_no_clear", clear_cnt - c0, 0);
    check_eq("clear_tick_overlap", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
